// File: rtl/instr_encoder.sv
// Instruction encoder: packs field bundles into 16-bit words and streams them
// through a one-entry write buffer to instruction memory at incrementing addresses.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [1:0]  in_func,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic [2:0]  in_rd,
  input  logic [10:0] in_imm,
  input  logic        mem_stall,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] insn_count,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        buf_vld_q, buf_vld_d;
  logic [15:0] buf_addr_q, buf_addr_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;

  logic start_ok;
  logic accept;
  logic complete;

  // Every 5-bit opcode maps to exactly one format; I1 covers the remaining codes.
  function automatic logic [15:0] encode(
    input logic [4:0]  op,
    input logic [1:0]  func,
    input logic [2:0]  rs,
    input logic [2:0]  rt,
    input logic [2:0]  rd,
    input logic [10:0] imm
  );
    logic [15:0] w;
    casez (op)
      5'b000??:                         w = {op, 11'd0};
      5'b00100, 5'b00110:               w = {op, imm};
      5'b00101, 5'b00111, 5'b011??,
      5'b10010, 5'b11000:               w = {op, rs, imm[7:0]};
      5'b11001:                         w = {op, rs, 3'b000, rd, 2'b00};
      5'b11010, 5'b11011, 5'b111??:     w = {op, rs, rt, rd, func};
      default:                          w = {op, rs, rd, imm[4:0]};
    endcase
    return w;
  endfunction

  assign in_ready = (state_q == S_RUN) && (!buf_vld_q || !mem_stall);
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept   = in_valid && in_ready;
  assign complete = buf_vld_q && !mem_stall;

  always_comb begin
    state_d    = state_q;
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_RUN;
      S_RUN:          if (accept && (in_op == 5'd0)) state_d = S_DRAIN;
      S_DRAIN:        if (!buf_vld_q || complete) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase

    if (start_ok) begin
      addr_d = base & 16'hFFFE;
    end else if (accept) begin
      addr_d = addr_q + 16'd2;
    end

    if (start_ok) begin
      cnt_d = 16'd0;
    end else if (complete && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    // A fresh acceptance refills the buffer even as the old word retires.
    if (accept) begin
      buf_vld_d  = 1'b1;
      buf_addr_d = addr_q;
      buf_data_d = encode(in_op, in_func, in_rs, in_rt, in_rd, in_imm);
    end else if (complete) begin
      buf_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      buf_vld_q  <= 1'b0;
      buf_addr_q <= 16'd0;
      buf_data_q <= 16'd0;
      addr_q     <= 16'd0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wr_en      = buf_vld_q;
  assign wr_addr    = buf_addr_q;
  assign wr_data    = buf_data_q;
  assign insn_count = cnt_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: per-cycle comparison against a behavioural model,
// plus directed scenarios with hand-computed words, addresses and counts.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [1:0]  in_func;
  logic [2:0]  in_rs, in_rt, in_rd;
  logic [10:0] in_imm;
  logic        mem_stall;
  logic        wr_en;
  logic [15:0] wr_addr, wr_data, insn_count;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  // Format letter per opcode 0..31: N none, J jump, 1 I1, 2 I2, B BTR, R register.
  string fmt = "NNNNJ2J211112222112111112BRRRRRR";

  // Behavioural model state: phase 0 idle, 1 run, 2 drain, 3 done.
  int m_phase = 0;
  bit m_pv    = 1'b0;
  int m_paddr = 0;
  int m_pdata = 0;
  int m_next  = 0;
  int m_count = 0;

  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];

  instr_encoder dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .base       (base),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_func    (in_func),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .mem_stall  (mem_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .insn_count (insn_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc(int op, int f, int s, int t, int d, int i);
    byte c;
    int  w;
    c = fmt[op];
    w = op * 2048;
    case (c)
      "R":     w += s * 256 + t * 32 + d * 4 + f;
      "B":     w += s * 256 + d * 4;
      "1":     w += s * 256 + d * 32 + (i % 32);
      "2":     w += s * 256 + (i % 256);
      "J":     w += i % 2048;
      default: ;
    endcase
    return w;
  endfunction

  // Model: advances on each rising edge from the inputs held during the cycle.
  initial begin
    int  old_phase;
    bit  old_pv, rdy, acc, cmp;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_pv = 1'b0; m_paddr = 0; m_pdata = 0; m_next = 0; m_count = 0;
      end else begin
        old_phase = m_phase;
        old_pv    = m_pv;
        rdy = (old_phase == 1) && (!old_pv || !mem_stall);
        acc = in_valid && rdy;
        cmp = old_pv && !mem_stall;
        if (cmp) begin
          m_pv = 1'b0;
          if (m_count < 65535) m_count++;
        end
        if (acc) begin
          m_paddr = m_next;
          m_pdata = enc(int'(in_op), int'(in_func), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
          m_pv    = 1'b1;
          m_next  = (m_next + 2) % 65536;
          if (in_op == 5'd0) m_phase = 2;
        end
        if ((old_phase == 0 || old_phase == 3) && start) begin
          m_phase = 1;
          m_next  = int'(base) - (int'(base) % 2);
          m_count = 0;
        end
        if (old_phase == 2 && (!old_pv || cmp)) m_phase = 3;
      end
    end
  end

  // Compare process on the falling edge, also logging every completed write.
  initial begin
    bit e_ready;
    forever begin
      @(negedge clk);
      e_ready = rst_n && (m_phase == 1) && (!m_pv || !mem_stall);
      chk("cyc_in_ready", in_ready, e_ready);
      chk("cyc_wr_en", wr_en, m_pv);
      if (m_pv || !rst_n) begin
        chk("cyc_wr_addr", wr_addr, m_paddr[15:0]);
        chk("cyc_wr_data", wr_data, m_pdata[15:0]);
      end
      chk("cyc_insn_count", insn_count, m_count[15:0]);
      chk("cyc_busy", busy, (m_phase == 1 || m_phase == 2));
      chk("cyc_done", done, (m_phase == 3));
      if (rst_n && wr_en && !mem_stall) begin
        log_addr.push_back(wr_addr);
        log_data.push_back(wr_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] o, input logic [1:0] f, input logic [2:0] s,
                      input logic [2:0] t, input logic [2:0] d, input logic [10:0] i);
    bit got;
    got = 1'b0;
    in_op = o; in_func = f; in_rs = s; in_rt = t; in_rd = d; in_imm = i;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("push_accept_timeout", got, 1'b1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic chk_log(input int idx, input logic [15:0] a, input logic [15:0] d);
    if (idx < log_addr.size()) begin
      chk($sformatf("log%0d_addr", idx), log_addr[idx], a);
      chk($sformatf("log%0d_data", idx), log_data[idx], d);
    end else begin
      chk($sformatf("log%0d_missing", idx), log_addr.size(), idx + 1);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; base = 16'd0; in_valid = 1'b0;
    in_op = 5'd0; in_func = 2'd0; in_rs = 3'd0; in_rt = 3'd0; in_rd = 3'd0; in_imm = 11'd0;
    mem_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 16'h0000);
    chk("rst_wr_data", wr_data, 16'h0000);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", insn_count, 16'h0000);
    rst_n = 1'b1;
    cyc();
    chk("idle_busy", busy, 1'b0);

    // Run 1: encodings, back-to-back flow and a 3-cycle stall.
    start = 1'b1; base = 16'h0100;
    cyc();
    start = 1'b0; base = 16'h0000;
    push(5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 11'h005);
    chk("addi_wr_en", wr_en, 1'b1);
    chk("addi_addr", wr_addr, 16'h0100);
    chk("addi_data", wr_data, 16'h4145);
    push(5'b11011, 2'b01, 3'd3, 3'd4, 3'd5, 11'h000);
    chk("r_addr", wr_addr, 16'h0102);
    chk("r_data", wr_data, 16'hDB95);
    push(5'b00100, 2'd0, 3'd0, 3'd0, 3'd0, 11'h7FF);
    chk("j_addr", wr_addr, 16'h0104);
    chk("j_data", wr_data, 16'h27FF);
    push(5'b00101, 2'd0, 3'd2, 3'd0, 3'd0, 11'h03C);
    mem_stall = 1'b1;
    in_op = 5'b11001; in_func = 2'd3; in_rs = 3'd7; in_rt = 3'd5; in_rd = 3'd6; in_imm = 11'd0;
    in_valid = 1'b1;
    #1;
    chk("stall_in_ready", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_wr_en", wr_en, 1'b1);
      chk("stall_data", wr_data, 16'h2A3C);
      chk("stall_addr", wr_addr, 16'h0106);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    mem_stall = 1'b0;
    push(5'b11001, 2'd3, 3'd7, 3'd5, 3'd6, 11'd0);
    chk("btr_data", wr_data, 16'hCF18);
    push(5'b00011, 2'd0, 3'd0, 3'd0, 3'd0, 11'h7FF);
    push(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h123);
    wait_done();
    chk("run1_count", insn_count, 16'd7);
    chk_log(0, 16'h0100, 16'h4145);
    chk_log(1, 16'h0102, 16'hDB95);
    chk_log(2, 16'h0104, 16'h27FF);
    chk_log(3, 16'h0106, 16'h2A3C);
    chk_log(4, 16'h0108, 16'hCF18);
    chk_log(5, 16'h010A, 16'h1800);
    chk_log(6, 16'h010C, 16'h0000);

    // Run 2: address wrap from 0xFFFE.
    cyc();
    start = 1'b1; base = 16'hFFFE;
    cyc();
    start = 1'b0;
    chk("run2_count_clear", insn_count, 16'd0);
    push(5'b10100, 2'd0, 3'd4, 3'd0, 3'd3, 11'h01F);
    chk("wrap_addr0", wr_addr, 16'hFFFE);
    push(5'b00110, 2'd0, 3'd0, 3'd0, 3'd0, 11'h400);
    chk("wrap_addr1", wr_addr, 16'h0000);
    push(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000);
    wait_done();
    chk("run2_count", insn_count, 16'd3);
    chk_log(7, 16'hFFFE, 16'hA47F);
    chk_log(8, 16'h0000, 16'h3400);
    chk_log(9, 16'h0002, 16'h0000);

    // Run 3: odd base, three words then HALT, truncated immediates.
    cyc();
    start = 1'b1; base = 16'h0201;
    cyc();
    start = 1'b0;
    push(5'b11111, 2'd2, 3'd0, 3'd7, 3'd1, 11'h000);
    push(5'b10011, 2'd0, 3'd5, 3'd0, 3'd5, 11'h7E3);
    push(5'b11000, 2'd0, 3'd1, 3'd0, 3'd0, 11'h5AB);
    push(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000);
    wait_done();
    chk("halt_done", done, 1'b1);
    chk("halt_count", insn_count, 16'd4);
    chk("halt_in_ready", in_ready, 1'b0);
    chk_log(10, 16'h0200, 16'hF8E6);
    chk_log(11, 16'h0202, 16'h9DA3);
    chk_log(12, 16'h0204, 16'hC1AB);
    chk_log(13, 16'h0206, 16'h0000);

    // Restart clears the count; then reset with a stalled pending write.
    cyc();
    start = 1'b1; base = 16'h0300;
    cyc();
    start = 1'b0;
    chk("restart_count", insn_count, 16'd0);
    push(5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 11'h005);
    mem_stall = 1'b1;
    cyc();
    chk("pend_wr_en", wr_en, 1'b1);
    n = log_addr.size();
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    repeat (2) cyc();
    rst_n = 1'b1;
    mem_stall = 1'b0;
    in_op = 5'b01000; in_rs = 3'd1; in_rd = 3'd2; in_imm = 11'h005;
    in_valid = 1'b1;
    repeat (5) cyc();
    chk("post_rst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    cyc();
    chk("post_rst_no_write", log_addr.size(), n);
    chk("post_rst_wr_en", wr_en, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_done", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
